// File: rtl/reg_write_arb_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
package reg_write_arb_pkg;
   localparam int DEF_DATA_W     = 16;
   localparam int DEF_ADDR_W     = 3;
   localparam int DEF_FIFO_DEPTH = 2;

   typedef struct packed {
      logic [DEF_ADDR_W-1:0] dest;
      logic [DEF_DATA_W-1:0] data;
   } write_req_t;

   typedef enum logic {REQ0 = 1'b0, REQ1 = 1'b1} req_idx_t;
endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester handshakes and register-file write port of the write arbiter.
interface reg_write_arbiter_if
   import reg_write_arb_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
);
   logic                   req0_valid, req0_ready;
   logic [ADDR_W-1:0]      req0_dest;
   logic [DATA_W-1:0]      req0_data;
   logic                   req1_valid, req1_ready;
   logic [ADDR_W-1:0]      req1_dest;
   logic [DATA_W-1:0]      req1_data;
   logic                   reg_write_en;
   logic [ADDR_W-1:0]      reg_write_dest;
   logic [DATA_W-1:0]      reg_write_data;
   logic [(1<<ADDR_W)-1:0] pending_mask;
   logic                   idle;

   modport master (
      output req0_valid, req0_dest, req0_data, req1_valid, req1_dest, req1_data,
      input  req0_ready, req1_ready, reg_write_en, reg_write_dest, reg_write_data,
             pending_mask, idle
   );

   modport slave (
      input  req0_valid, req0_dest, req0_data, req1_valid, req1_dest, req1_data,
      output req0_ready, req1_ready, reg_write_en, reg_write_dest, reg_write_data,
             pending_mask, idle
   );
endinterface

// File: rtl/reg_write_fifo.sv
// Per-requester write FIFO; exposes every slot's dest and valid bit for the pending mask.
module reg_write_fifo
   import reg_write_arb_pkg::*;
#(
   parameter type T      = write_req_t,
   parameter int  ADDR_W = DEF_ADDR_W,
   parameter int  DEPTH  = DEF_FIFO_DEPTH
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         push_i,
   input  T                             wdata_i,
   input  logic                         pop_i,
   output T                             head_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [DEPTH-1:0][ADDR_W-1:0] dest_o,
   output logic [DEPTH-1:0]             vld_o
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   T                 mem_q [DEPTH];
   logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [DEPTH-1:0] vld_q, vld_d;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      rd_d  = rd_q;
      wr_d  = wr_q;
      cnt_d = cnt_q;
      vld_d = vld_q;
      if (pop_i) begin
         rd_d        = inc(rd_q);
         vld_d[rd_q] = 1'b0;
      end
      if (push_i) begin
         wr_d        = inc(wr_q);
         vld_d[wr_q] = 1'b1;
      end
      case ({push_i, pop_i})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
         vld_q <= '0;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
         vld_q <= vld_d;
      end
   end

   // Payload needs no reset: slot validity lives in vld_q.
   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_q] <= wdata_i;
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) dest_o[i] = mem_q[i].dest;
   end

   assign head_o  = mem_q[rd_q];
   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign vld_o   = vld_q;
endmodule

// File: rtl/reg_write_arbiter.sv
// Register-file write-port arbiter: two requester FIFOs, one registered write per cycle, pending mask.
// Define REG_WRITE_ARB_RR_EN for round-robin on contention; default is fixed priority to requester 0.
module reg_write_arbiter
   import reg_write_arb_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input logic                clk,
   input logic                rst,
   reg_write_arbiter_if.slave bus
);
   typedef struct packed {
      logic [ADDR_W-1:0] dest;
      logic [DATA_W-1:0] data;
   } req_t;

   localparam int NREG = 1 << ADDR_W;

   req_t                              in0, in1, head0, head1, win;
   logic                              push0, push1, pop0, pop1;
   logic                              full0, full1, empty0, empty1;
   logic [FIFO_DEPTH-1:0][ADDR_W-1:0] dest0, dest1;
   logic [FIFO_DEPTH-1:0]             vld0, vld1;
   logic                              gnt_v;
   req_idx_t                          gnt, pick;
   logic                              wr_en_q;
   logic [ADDR_W-1:0]                 wr_dest_q;
   logic [DATA_W-1:0]                 wr_data_q;
   logic [NREG-1:0]                   pend;

   assign in0   = req_t'{dest: bus.req0_dest, data: bus.req0_data};
   assign in1   = req_t'{dest: bus.req1_dest, data: bus.req1_data};
   assign push0 = bus.req0_valid & ~full0;
   assign push1 = bus.req1_valid & ~full1;

   reg_write_fifo #(.T(req_t), .ADDR_W(ADDR_W), .DEPTH(FIFO_DEPTH)) u_fifo0 (
      .clk_i(clk), .rst_ni(rst), .push_i(push0), .wdata_i(in0), .pop_i(pop0),
      .head_o(head0), .full_o(full0), .empty_o(empty0), .dest_o(dest0), .vld_o(vld0));

   reg_write_fifo #(.T(req_t), .ADDR_W(ADDR_W), .DEPTH(FIFO_DEPTH)) u_fifo1 (
      .clk_i(clk), .rst_ni(rst), .push_i(push1), .wdata_i(in1), .pop_i(pop1),
      .head_o(head1), .full_o(full1), .empty_o(empty1), .dest_o(dest1), .vld_o(vld1));

`ifdef REG_WRITE_ARB_RR_EN
   req_idx_t last_q;

   // Reset to "requester 1 won last" so the first contested grant goes to requester 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                  last_q <= REQ1;
      else if (!empty0 && !empty1) last_q <= gnt;
   end

   assign pick = (last_q == REQ0) ? REQ1 : REQ0;
`else
   assign pick = REQ0;
`endif

   always_comb begin
      gnt = REQ0;
      if (empty0)       gnt = REQ1;
      else if (!empty1) gnt = pick;
   end

   assign gnt_v = ~(empty0 & empty1);
   assign pop0  = gnt_v && (gnt == REQ0);
   assign pop1  = gnt_v && (gnt == REQ1);
   assign win   = (gnt == REQ1) ? head1 : head0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_en_q   <= 1'b0;
         wr_dest_q <= '0;
         wr_data_q <= '0;
      end else begin
         wr_en_q <= gnt_v;
         if (gnt_v) begin
            wr_dest_q <= win.dest;
            wr_data_q <= win.data;
         end
      end
   end

   always_comb begin
      pend = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (vld0[i]) pend[dest0[i]] = 1'b1;
         if (vld1[i]) pend[dest1[i]] = 1'b1;
      end
      if (wr_en_q) pend[wr_dest_q] = 1'b1;
   end

   assign bus.req0_ready     = ~full0;
   assign bus.req1_ready     = ~full1;
   assign bus.reg_write_en   = wr_en_q;
   assign bus.reg_write_dest = wr_dest_q;
   assign bus.reg_write_data = wr_data_q;
   assign bus.pending_mask   = pend;
   assign bus.idle           = empty0 & empty1 & ~wr_en_q;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed scenarios plus a random run against a queue model.
module tb_reg_write_arbiter;
   import reg_write_arb_pkg::*;

   localparam int DEPTH = 2;
`ifdef REG_WRITE_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   typedef struct {
      logic [2:0]  dest;
      logic [15:0] data;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   reg_write_arbiter_if bus ();
   reg_write_arbiter #(.DATA_W(16), .ADDR_W(3), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .bus(bus));

   int errors = 0;
   int checks = 0;

   // Model: per-requester queues, output register, last contested winner, register file.
   ent_t        q0[$], q1[$];
   logic        m_en;
   logic [2:0]  m_dest;
   logic [15:0] m_data;
   int          m_last;
   int          m_acc0, m_acc1;
   logic [15:0] m_rf   [8];
   logic [15:0] rf_obs [8];
   int          obs_acc1;

   function automatic logic [7:0] exp_pending();
      logic [7:0] m = '0;
      foreach (q0[i]) m[q0[i].dest] = 1'b1;
      foreach (q1[i]) m[q1[i].dest] = 1'b1;
      if (m_en) m[m_dest] = 1'b1;
      return m;
   endfunction

   task automatic model_reset();
      q0.delete();
      q1.delete();
      m_en   = 1'b0;
      m_dest = '0;
      m_data = '0;
      m_last = 1;
   endtask

   task automatic set_in(input logic v0, input logic [2:0] d0, input logic [15:0] x0,
                         input logic v1, input logic [2:0] d1, input logic [15:0] x1);
      bus.req0_valid = v0; bus.req0_dest = d0; bus.req0_data = x0;
      bus.req1_valid = v1; bus.req1_dest = d1; bus.req1_data = x1;
   endtask

   // One clock: the DUT's register file captures, the model advances, then outputs settle.
   task automatic tick();
      logic v0, v1, a0, a1, h0, h1;
      int   win;
      ent_t e0, e1, w;
      v0 = bus.req0_valid; e0.dest = bus.req0_dest; e0.data = bus.req0_data;
      v1 = bus.req1_valid; e1.dest = bus.req1_dest; e1.data = bus.req1_data;
      if (bus.reg_write_en === 1'b1) rf_obs[bus.reg_write_dest] = bus.reg_write_data;
      if (v1 && bus.req1_ready === 1'b1) obs_acc1++;
      @(posedge clk);
      if (m_en) m_rf[m_dest] = m_data;
      a0 = v0 && (q0.size() < DEPTH);
      a1 = v1 && (q1.size() < DEPTH);
      h0 = q0.size() > 0;
      h1 = q1.size() > 0;
      win = h0 ? 0 : 1;
      if (h0 && h1) begin
         win    = (RR && m_last == 0) ? 1 : 0;
         m_last = win;
      end
      m_en = h0 || h1;
      if (m_en) begin
         if (win == 0) w = q0.pop_front();
         else          w = q1.pop_front();
         m_dest = w.dest;
         m_data = w.data;
      end
      if (a0) begin q0.push_back(e0); m_acc0++; end
      if (a1) begin q1.push_back(e1); m_acc1++; end
      #1;
   endtask

   task automatic drain();
      set_in(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 20 && bus.idle !== 1'b1; i++) tick();
   endtask

   task automatic test_reset();
      #1 rst = 1'b0;
      #2;
      checks += 7;
      if (bus.reg_write_en !== 1'b0)     begin errors++; $display("FAIL reset_en: got %b want 0", bus.reg_write_en); end
      if (bus.reg_write_dest !== 3'd0)   begin errors++; $display("FAIL reset_dest: got %h want 0", bus.reg_write_dest); end
      if (bus.reg_write_data !== 16'd0)  begin errors++; $display("FAIL reset_data: got %h want 0", bus.reg_write_data); end
      if (bus.pending_mask !== 8'h00)    begin errors++; $display("FAIL reset_pending: got %h want 00", bus.pending_mask); end
      if (bus.req0_ready !== 1'b1)       begin errors++; $display("FAIL reset_ready0: got %b want 1", bus.req0_ready); end
      if (bus.req1_ready !== 1'b1)       begin errors++; $display("FAIL reset_ready1: got %b want 1", bus.req1_ready); end
      if (bus.idle !== 1'b1)             begin errors++; $display("FAIL reset_idle: got %b want 1", bus.idle); end
      #9 rst = 1'b1;
   endtask

   task automatic test_single_write();
      set_in(1, 3'd3, 16'hA5A5, 0, 0, 0);
      tick();
      set_in(0, 0, 0, 0, 0, 0);
      checks += 2;
      if (bus.pending_mask !== 8'h08) begin errors++; $display("FAIL single_pend_e: got %h want 08", bus.pending_mask); end
      if (bus.reg_write_en !== 1'b0)  begin errors++; $display("FAIL single_early_en: got %b want 0", bus.reg_write_en); end
      tick();
      checks += 4;
      if (bus.reg_write_en !== 1'b1)       begin errors++; $display("FAIL single_en: got %b want 1", bus.reg_write_en); end
      if (bus.reg_write_dest !== 3'd3)     begin errors++; $display("FAIL single_dest: got %0d want 3", bus.reg_write_dest); end
      if (bus.reg_write_data !== 16'hA5A5) begin errors++; $display("FAIL single_data: got %h want a5a5", bus.reg_write_data); end
      if (bus.pending_mask !== 8'h08)      begin errors++; $display("FAIL single_pend_e1: got %h want 08", bus.pending_mask); end
      tick();
      checks += 4;
      if (bus.reg_write_en !== 1'b0)  begin errors++; $display("FAIL single_en_off: got %b want 0", bus.reg_write_en); end
      if (bus.pending_mask !== 8'h00) begin errors++; $display("FAIL single_pend_clr: got %h want 00", bus.pending_mask); end
      if (bus.idle !== 1'b1)          begin errors++; $display("FAIL single_idle: got %b want 1", bus.idle); end
      if (rf_obs[3] !== 16'hA5A5)     begin errors++; $display("FAIL single_rf: got %h want a5a5", rf_obs[3]); end
   endtask

   task automatic test_same_dest();
      set_in(1, 3'd5, 16'd1, 0, 0, 0);
      tick();
      checks++;
      if (bus.pending_mask[5] !== 1'b1) begin errors++; $display("FAIL same_pend1: got %b want 1", bus.pending_mask[5]); end
      set_in(1, 3'd5, 16'd2, 0, 0, 0);
      tick();
      set_in(0, 0, 0, 0, 0, 0);
      checks += 2;
      if (bus.reg_write_en !== 1'b1 || bus.reg_write_data !== 16'd1) begin errors++; $display("FAIL same_first: got en=%b data=%0d want en=1 data=1", bus.reg_write_en, bus.reg_write_data); end
      if (bus.pending_mask[5] !== 1'b1) begin errors++; $display("FAIL same_pend2: got %b want 1", bus.pending_mask[5]); end
      tick();
      checks += 2;
      if (bus.reg_write_en !== 1'b1 || bus.reg_write_data !== 16'd2) begin errors++; $display("FAIL same_second: got en=%b data=%0d want en=1 data=2", bus.reg_write_en, bus.reg_write_data); end
      if (bus.pending_mask[5] !== 1'b1) begin errors++; $display("FAIL same_pend3: got %b want 1", bus.pending_mask[5]); end
      tick();
      checks += 2;
      if (bus.pending_mask[5] !== 1'b0) begin errors++; $display("FAIL same_pend_clr: got %b want 0", bus.pending_mask[5]); end
      if (rf_obs[5] !== 16'd2)          begin errors++; $display("FAIL same_rf: got %0d want 2", rf_obs[5]); end
   endtask

   task automatic test_contention();
      int k, b_obs, b_mod;
      logic [2:0] exp_d;
      k = 0;
      b_obs = obs_acc1;
      b_mod = m_acc1;
      for (int c = 0; c < 6; c++) begin
         set_in(1, 3'd1, 16'($urandom), 1, 3'd2, 16'($urandom));
         tick();
         if (bus.reg_write_en === 1'b1) begin
            exp_d = (RR && (k % 2 == 1)) ? 3'd2 : 3'd1;
            checks++;
            if (bus.reg_write_dest !== exp_d) begin errors++; $display("FAIL contend_grant%0d: got dest %0d want %0d", k, bus.reg_write_dest, exp_d); end
            k++;
         end
      end
      checks += 3;
      if (k !== 5) begin errors++; $display("FAIL contend_count: got %0d grants want 5", k); end
      if (obs_acc1 - b_obs !== m_acc1 - b_mod) begin errors++; $display("FAIL contend_req1_xfers: got %0d want %0d", obs_acc1 - b_obs, m_acc1 - b_mod); end
      if (bus.req1_ready !== (q1.size() < DEPTH)) begin errors++; $display("FAIL contend_ready1: got %b want %b", bus.req1_ready, q1.size() < DEPTH); end
      drain();
      checks++;
      if (bus.idle !== 1'b1) begin errors++; $display("FAIL contend_drain: idle got %b want 1", bus.idle); end
   endtask

   task automatic test_fifo_full();
      int sent, base, pop_c, t3;
      sent = 0; pop_c = -1; t3 = -1;
      base = obs_acc1;
      for (int c = 0; c < 30; c++) begin
         set_in(c < 8, 3'd0, 16'($urandom), sent < 3, 3'(4 + sent), 16'(16'h0100 + sent));
         tick();
         if (obs_acc1 - base != sent) begin
            sent = obs_acc1 - base;
            if (sent == 3) t3 = c;
         end
         if (pop_c < 0 && bus.reg_write_en === 1'b1 && bus.reg_write_dest >= 3'd4) pop_c = c;
         checks++;
         if (bus.req1_ready !== (q1.size() < DEPTH)) begin errors++; $display("FAIL full_ready1_c%0d: got %b want %b", c, bus.req1_ready, q1.size() < DEPTH); end
      end
      checks += 2;
      if (pop_c < 0 || t3 !== pop_c + 1) begin errors++; $display("FAIL full_third_xfer: got edge %0d want %0d", t3, pop_c + 1); end
      drain();
      if (rf_obs[6] !== 16'h0102) begin errors++; $display("FAIL full_rf6: got %h want 0102", rf_obs[6]); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         set_in($urandom_range(0, 9) < 6, 3'($urandom), 16'($urandom),
                $urandom_range(0, 9) < 5, 3'($urandom), 16'($urandom));
         tick();
         checks += 5;
         if (bus.reg_write_en !== m_en)          begin errors++; $display("FAIL rand_en_c%0d: got %b want %b", c, bus.reg_write_en, m_en); end
         if (bus.pending_mask !== exp_pending()) begin errors++; $display("FAIL rand_pend_c%0d: got %h want %h", c, bus.pending_mask, exp_pending()); end
         if (bus.req0_ready !== (q0.size() < DEPTH)) begin errors++; $display("FAIL rand_ready0_c%0d: got %b", c, bus.req0_ready); end
         if (bus.req1_ready !== (q1.size() < DEPTH)) begin errors++; $display("FAIL rand_ready1_c%0d: got %b", c, bus.req1_ready); end
         if (bus.idle !== (q0.size() == 0 && q1.size() == 0 && !m_en)) begin errors++; $display("FAIL rand_idle_c%0d: got %b", c, bus.idle); end
         if (m_en) begin
            checks++;
            if (bus.reg_write_dest !== m_dest || bus.reg_write_data !== m_data) begin errors++; $display("FAIL rand_wr_c%0d: got %0d/%h want %0d/%h", c, bus.reg_write_dest, bus.reg_write_data, m_dest, m_data); end
         end
      end
      drain();
      tick();
      for (int r = 0; r < 8; r++) begin
         checks++;
         if (rf_obs[r] !== m_rf[r]) begin errors++; $display("FAIL rand_rf%0d: got %h want %h", r, rf_obs[r], m_rf[r]); end
      end
   endtask

   task automatic test_reset_mid();
      for (int c = 0; c < 3; c++) begin
         set_in(1, 3'd1, 16'($urandom), 1, 3'd2, 16'($urandom));
         tick();
      end
      #2 rst = 1'b0;
      #1;
      checks += 6;
      if (bus.reg_write_en !== 1'b0)    begin errors++; $display("FAIL mid_en: got %b want 0", bus.reg_write_en); end
      if (bus.reg_write_dest !== 3'd0 || bus.reg_write_data !== 16'd0) begin errors++; $display("FAIL mid_out: got %0d/%h want 0/0", bus.reg_write_dest, bus.reg_write_data); end
      if (bus.pending_mask !== 8'h00)   begin errors++; $display("FAIL mid_pend: got %h want 00", bus.pending_mask); end
      if (bus.idle !== 1'b1)            begin errors++; $display("FAIL mid_idle: got %b want 1", bus.idle); end
      if (bus.req0_ready !== 1'b1)      begin errors++; $display("FAIL mid_ready0: got %b want 1", bus.req0_ready); end
      if (bus.req1_ready !== 1'b1)      begin errors++; $display("FAIL mid_ready1: got %b want 1", bus.req1_ready); end
      set_in(0, 0, 0, 0, 0, 0);
      #2 rst = 1'b1;
      model_reset();
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++;
         if (bus.reg_write_en !== 1'b0 || bus.idle !== 1'b1) begin errors++; $display("FAIL mid_stale_c%0d: en=%b idle=%b want 0/1", c, bus.reg_write_en, bus.idle); end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int r = 0; r < 8; r++) begin m_rf[r] = '0; rf_obs[r] = '0; end
      m_acc0 = 0; m_acc1 = 0; obs_acc1 = 0;
      model_reset();
      set_in(0, 0, 0, 0, 0, 0);
      test_reset();
      test_single_write();
      test_same_dest();
      test_contention();
      test_fifo_full();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Shares the register file's single write port (reg_write_en / reg_write_dest / reg_write_data) between two write requesters: requester 0 is the pipeline writeback stage, requester 1 is the load/debug write path. Each requester gets a small FIFO with a valid/ready handshake. An arbiter issues at most one buffered write per cycle into registered outputs that drive `register_file` directly. A per-register pending mask is exported so hazard logic can stall reads of registers with queued writes.

## Interface
- `DATA_W`, default 16: register data width.
- `ADDR_W`, default 3: register address width; there are 2**ADDR_W registers.
- `FIFO_DEPTH`, default 2: entries per requester FIFO; must be ≥1.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req0_valid`  in  1  requester 0 has a write.
- `req0_ready`  out  1  requester 0 FIFO can accept.
- `req0_dest`  in  ADDR_W  requester 0 destination register.
- `req0_data`  in  DATA_W  requester 0 write data.
- `req1_valid`, `req1_ready`, `req1_dest`, `req1_data`  same as requester 0, for requester 1.
- `reg_write_en`  out  1  write strobe to register file.
- `reg_write_dest`  out  ADDR_W  register file write address.
- `reg_write_data`  out  DATA_W  register file write data.
- `pending_mask`  out  2**ADDR_W  bit i set when any write to register i is queued or issued but not yet committed.
- `idle`  out  1  both FIFOs are empty and reg_write_en is 0.

## Operation
- Handshake: a transfer occurs on a rising edge when `reqN_valid && reqN_ready`. `reqN_ready = (countN < FIFO_DEPTH)` and depends only on registered count, with no combinational path from valid or grant. When a FIFO is full, it does not accept a new entry on the same edge it dequeues; ready rises the cycle after.
- Valid may drop without a transfer. dest and data are sampled only on a transfer.
- Arbitration is evaluated every cycle over the non-empty FIFO heads:
  - exactly one head non-empty → grant it;
  - both non-empty → grant per policy (see Configuration);
  - none → no grant.
- On a grant, the granted head is popped, and the output registers are loaded at the same edge: `reg_write_en`=1, with the head's dest and data.
- With no grant, `reg_write_en`=0 and dest/data hold their last values.
- Ordering:
  - strict FIFO order within a requester;
  - across requesters, commit order equals grant order;
  - same-dest writes from both requesters commit in grant order, and the last one wins.
- No address filtering: dest 0 is forwarded like any other address, and `register_file` owns r0 semantics.
- `pending_mask` is the OR of the one-hot dest over all valid FIFO entries plus the output register when `reg_write_en`=1. It is computed combinationally from registered state.
- Reset (`rst`=0, at any time):
  - FIFOs flushed and counts 0;
  - queued writes discarded;
  - `reg_write_en`=0, `reg_write_dest`=0, `reg_write_data`=0;
  - `pending_mask`=0, `req0_ready`=`req1_ready`=1, `idle`=1;
  - the round-robin pointer is set to favour requester 0.

## Timing
- Transfer at edge E → earliest `reg_write_en`=1 in the cycle after edge E+1 → `register_file` captures the write at edge E+2. Minimum latency is 2 edges, and there is no bypass around the FIFO.
- Throughput: one write per cycle sustained. Each requester alone sustains 1/cycle with `FIFO_DEPTH` ≥ 2 (FIFO_DEPTH=1 sustains 1 per 2 cycles).
- The `pending_mask` bit for a dest sets in the cycle after its transfer edge and clears in the cycle after its commit edge, unless another entry with the same dest remains queued.
- Simultaneous transfer into both FIFOs on one edge is allowed.
- Reset is asynchronous: outputs reach reset values without waiting for a clock edge. Deassertion is assumed synchronised upstream.

## Configuration
- `REG_WRITE_ARB_RR_EN` defined → round-robin:
  - when both heads are non-empty, grant the requester not granted last;
  - the pointer updates only on a contested grant;
  - no requester waits more than one contested grant.
- Undefined → fixed priority: requester 0 always wins contention, and requester 1 may starve under continuous requester 0 traffic.

## Structure
- Package `reg_write_arb_pkg`: `DATA_W`/`ADDR_W` defaults, typedef `write_req_t` {dest, data}, and requester index typedef.
- Sub-module `reg_write_fifo` (parameterised `write_req_t` FIFO with count, push/pop, full/empty), instantiated twice.
- Arbiter, output registers and pending-mask logic live in the top.

## Test plan
- Single write, requester 0 pushes dest=3, data=16'hA5A5 at edge E → `reg_write_en`=1 with dest 3 / A5A5 after edge E+1; `pending_mask`=8'h08 from E+1 until after commit.
- Contention, both requesters push every cycle (req0 dest 1, req1 dest 2):
  - with RR_EN, grants alternate 0,1,0,1;
  - without it, only requester 0 is granted, and `req1_ready` drops after 2 transfers.
- FIFO full, requester 1 alone pushes 3 writes back-to-back with FIFO_DEPTH=2 while requester 0 floods → `req1_ready`=0 after 2 transfers; the third transfer occurs only after a requester 1 pop.
- Same-dest ordering, requester 0 writes r5=1 and r5=2 in order → commits 1 then 2, and the register file reads r5=2; `pending_mask[5]` clears only after the second commit.
- Reset mid-operation, assert `rst`=0 with both FIFOs holding entries → outputs immediately 0, `idle`=1, and no queued write is issued after reset release.
